// File: rtl/rans_decoder_stream.sv
// rans_decoder_stream: single-stream rANS decoder.
// Rebuilds a slot-to-symbol table from the frequency/cumulative table and then
// decodes symbols from 16-bit renormalization words supplied in decode order.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | after reset, waiting for restart_i; table writes accepted
// BUILD    | fill slot table from freq/cum table, one slot per cycle
// LOAD_HI  | accept first word into x[31:16]
// LOAD_LO  | accept second word into x[15:0]
// LOOKUP   | read slot table at x[RESOLUTION-1:0]
// FETCH    | read freq/cum of the symbol returned by the slot table
// EMIT     | present symbol, advance x when downstream accepts
// RENORM   | shift one word into x after x fell below L
// DONE     | stream finished, err_o valid; table writes accepted
module rans_decoder_stream #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      freq_wr_i,
    input  logic [SYMBOL_WIDTH-1:0]   freq_addr_i,
    input  logic [RESOLUTION:0]       freq_i,
    input  logic [RESOLUTION-1:0]     cum_freq_i,
    input  logic                      restart_i,
    input  logic [31:0]               count_i,
    input  logic                      word_valid_i,
    input  logic [2*SYMBOL_WIDTH-1:0] word_i,
    output logic                      word_ready_o,
    output logic                      symb_valid_o,
    output logic [SYMBOL_WIDTH-1:0]   symb_o,
    input  logic                      symb_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int NSYM = 1 << SYMBOL_WIDTH;
    localparam int M    = 1 << RESOLUTION;
    localparam logic [31:0] L_STATE = 32'h0001_0000;

    localparam logic [1:0] PH_PRIME = 2'd0;
    localparam logic [1:0] PH_RUN   = 2'd1;
    localparam logic [1:0] PH_FLUSH = 2'd2;

    localparam logic [RESOLUTION:0]     ONE_F = 1;
    localparam logic [SYMBOL_WIDTH-1:0] ONE_P = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BUILD,
        S_LOAD_HI,
        S_LOAD_LO,
        S_LOOKUP,
        S_FETCH,
        S_EMIT,
        S_RENORM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [RESOLUTION:0]       freq_mem [NSYM];
    logic [RESOLUTION-1:0]     cum_mem  [NSYM];
    logic [SYMBOL_WIDTH-1:0]   slot_mem [M];

    logic [RESOLUTION:0]       fc_freq_q;
    logic [RESOLUTION-1:0]     fc_cum_q;
    logic [SYMBOL_WIDTH-1:0]   slot_q;

    logic [1:0]                build_ph_q;
    logic [SYMBOL_WIDTH-1:0]   p_q;
    logic [RESOLUTION:0]       k_q;
    logic [31:0]               x_q;
    logic [31:0]               count_q;

    logic                      freq_we;
    logic                      fc_rd_en;
    logic [SYMBOL_WIDTH-1:0]   fc_rd_addr;
    logic                      slot_we;
    logic                      slot_rd_en;
    logic [RESOLUTION-1:0]     slot_wr_addr;
    logic                      build_last;
    logic                      p_last;
    logic [31:0]               x_next;

    // Last slot of the current symbol; a zero-frequency symbol still takes one cycle.
    assign build_last   = (fc_freq_q == '0) || (k_q == fc_freq_q - ONE_F);
    assign p_last       = (p_q == '1);
    assign slot_wr_addr = fc_cum_q + k_q[RESOLUTION-1:0];

    // Decoder step; modulo-2^32 arithmetic matches the truncated 33-bit result.
    assign x_next = 32'(fc_freq_q) * (x_q >> RESOLUTION)
                  + 32'(x_q[RESOLUTION-1:0]) - 32'(fc_cum_q);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic, handshakes and RAM strobes.
    always_comb begin
        state_d      = state_q;
        word_ready_o = 1'b0;
        symb_valid_o = 1'b0;
        symb_o       = '0;
        busy_o       = (state_q != S_IDLE) && (state_q != S_DONE);
        done_o       = (state_q == S_DONE);
        err_o        = (state_q == S_DONE) && (x_q != L_STATE);
        freq_we      = freq_wr_i && ((state_q == S_IDLE) || (state_q == S_DONE));
        fc_rd_en     = 1'b0;
        fc_rd_addr   = '0;
        slot_we      = 1'b0;
        slot_rd_en   = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_BUILD: begin
                fc_rd_en = 1'b1;
                case (build_ph_q)
                    PH_RUN: begin
                        slot_we    = (fc_freq_q != '0);
                        fc_rd_addr = build_last ? p_q + ONE_P : p_q;
                    end
                    PH_FLUSH: state_d = S_LOAD_HI;
                    default:  fc_rd_addr = '0;
                endcase
            end
            S_LOAD_HI: begin
                word_ready_o = 1'b1;
                if (word_valid_i) state_d = S_LOAD_LO;
            end
            S_LOAD_LO: begin
                word_ready_o = 1'b1;
                if (word_valid_i) state_d = (count_q != '0) ? S_LOOKUP : S_DONE;
            end
            S_LOOKUP: begin
                slot_rd_en = 1'b1;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                fc_rd_en   = 1'b1;
                fc_rd_addr = slot_q;
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                symb_valid_o = 1'b1;
                symb_o       = slot_q;
                if (symb_ready_i) begin
                    if (x_next < L_STATE)       state_d = S_RENORM;
                    else if (count_q == 32'd1)  state_d = S_DONE;
                    else                        state_d = S_LOOKUP;
                end
            end
            S_RENORM: begin
                word_ready_o = 1'b1;
                if (word_valid_i) state_d = (count_q == '0) ? S_DONE : S_LOOKUP;
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase

        if (restart_i) state_d = S_BUILD;
    end

    // Frequency/cumulative table: host write port, synchronous read port.
    always_ff @(posedge clk_i) begin
        if (freq_we) begin
            freq_mem[freq_addr_i] <= freq_i;
            cum_mem[freq_addr_i]  <= cum_freq_i;
        end
        if (fc_rd_en) begin
            fc_freq_q <= freq_mem[fc_rd_addr];
            fc_cum_q  <= cum_mem[fc_rd_addr];
        end
    end

    // Slot-to-symbol table: written during BUILD, read in LOOKUP; read data held otherwise.
    always_ff @(posedge clk_i) begin
        if (slot_we)    slot_mem[slot_wr_addr] <= p_q;
        if (slot_rd_en) slot_q <= slot_mem[x_q[RESOLUTION-1:0]];
    end

    // Decoder state, symbol count and BUILD walk counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q        <= '0;
            count_q    <= '0;
            build_ph_q <= PH_PRIME;
            p_q        <= '0;
            k_q        <= '0;
        end else if (restart_i) begin
            x_q        <= '0;
            count_q    <= count_i;
            build_ph_q <= PH_PRIME;
            p_q        <= '0;
            k_q        <= '0;
        end else begin
            case (state_q)
                S_BUILD: begin
                    case (build_ph_q)
                        PH_PRIME: build_ph_q <= PH_RUN;
                        PH_RUN: begin
                            if (build_last) begin
                                k_q <= '0;
                                p_q <= p_q + ONE_P;
                                if (p_last) build_ph_q <= PH_FLUSH;
                            end else begin
                                k_q <= k_q + ONE_F;
                            end
                        end
                        default: ;
                    endcase
                end
                S_LOAD_HI: if (word_valid_i) x_q[31:16] <= word_i;
                S_LOAD_LO: if (word_valid_i) x_q[15:0]  <= word_i;
                S_EMIT: begin
                    if (symb_ready_i) begin
                        x_q     <= x_next;
                        count_q <= count_q - 32'd1;
                    end
                end
                S_RENORM: if (word_valid_i) x_q <= {x_q[15:0], word_i};
                default: ;
            endcase
        end
    end

endmodule
